// File: rtl/muldiv_sched.sv
// Sequencing controller for the EX-stage multiply/divide units: launches the multiplier or
// divider for one HI/LO op, stalls EX until the 64-bit result is captured, then presents {hi,lo}.
module muldiv_sched #(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall_hold,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic        stallreq,
   output logic        mul_start,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_opdata1,
   output logic [31:0] div_opdata2,
   output logic        div_annul,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        res_valid,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             op_div;
   logic             op_mul;
   logic             op_signed;
   logic             launch;

   // Priority decode of {div,divu,mult,multu}: div > divu > mult > multu
   always_comb begin
      op_div    = req_op[3] | req_op[2];
      op_mul    = !op_div && (req_op[1] | req_op[0]);
      op_signed = op_div ? req_op[3] : req_op[1];
   end

   // The multiplier is launched in the request cycle itself, so its controls are decoded from IDLE
   assign launch     = !rst && !flush && (state == IDLE);
   assign mul_start  = launch && op_mul;
   assign mul_signed = mul_start && op_signed;
   assign mul_ina    = mul_start ? req_src1 : 32'h0;
   assign mul_inb    = mul_start ? req_src2 : 32'h0;

   assign stallreq  = !rst && (((state == IDLE) && (req_op != 4'h0)) ||
                               (state == MUL_WAIT) || (state == DIV_RUN));
   assign div_start = !rst && !flush && (state == DIV_RUN);
   assign div_annul = (rst || flush) && (state == DIV_RUN);
   assign res_valid = (state == DONE);

   // Sequencer; flush beats everything except reset and drops any coincident div_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         hi_o        <= 32'h0;
         lo_o        <= 32'h0;
         div_signed  <= 1'b0;
         div_opdata1 <= 32'h0;
         div_opdata2 <= 32'h0;
      end else if (flush) begin
         state <= IDLE;
         hi_o  <= 32'h0;
         lo_o  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (op_mul) begin
                  cnt   <= CNT_W'(MUL_LAT - 1);
                  state <= MUL_WAIT;
               end else if (op_div) begin
                  if (req_src2 == 32'h0) begin
                     hi_o  <= req_src1;
                     lo_o  <= 32'hFFFF_FFFF;
                     state <= DONE;
                  end else begin
                     div_signed  <= op_signed;
                     div_opdata1 <= req_src1;
                     div_opdata2 <= req_src2;
                     state       <= DIV_RUN;
                  end
               end
            end
            MUL_WAIT: begin
               if (cnt == '0) begin
                  hi_o  <= mul_result[63:32];
                  lo_o  <= mul_result[31:0];
                  state <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DIV_RUN: begin
               if (div_ready) begin
                  hi_o  <= div_result[63:32];
                  lo_o  <= div_result[31:0];
                  state <= DONE;
               end
            end
            DONE: begin
               if (!stall_hold) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with behavioural pipelined multiplier and 33-cycle divider.
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        rst, flush, stall_hold;
   logic [3:0]  req_op;
   logic [31:0] req_src1, req_src2;
   logic        stallreq, mul_start, mul_signed;
   logic [31:0] mul_ina, mul_inb;
   logic [63:0] mul_result;
   logic        div_start, div_signed, div_annul, div_ready;
   logic [31:0] div_opdata1, div_opdata2;
   logic [63:0] div_result;
   logic        res_valid;
   logic [31:0] hi_o, lo_o;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];
   logic [63:0] last_exp = 64'h0;
   logic        rv_q = 1'b0;

   int   mul_starts    = 0;
   int   div_start_cyc = 0;
   logic last_msigned  = 1'b0;

   always #5 clk = ~clk;

   muldiv_sched #(.MUL_LAT(2), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall_hold(stall_hold),
      .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
      .stallreq(stallreq), .mul_start(mul_start), .mul_signed(mul_signed),
      .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
      .div_start(div_start), .div_signed(div_signed),
      .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
      .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
      .res_valid(res_valid), .hi_o(hi_o), .lo_o(lo_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Two-stage multiplier: product valid MUL_LAT=2 cycles after mul_start, garbage otherwise
   logic [63:0] mul_s1;
   always @(posedge clk) begin
      if (mul_start) begin
         if (mul_signed)
            mul_s1 <= $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
         else
            mul_s1 <= {32'h0, mul_ina} * {32'h0, mul_inb};
      end else begin
         mul_s1 <= 64'hDEAD_BEEF_DEAD_BEEF;
      end
      mul_result <= mul_s1;
   end

   // Divider: ready pulse 33 cycles after div_start is first seen; annul aborts
   logic busy = 1'b0;
   int   dcnt = 0;
   always @(posedge clk) begin
      div_ready <= 1'b0;
      if (rst || div_annul) begin
         busy <= 1'b0;
      end else if (busy) begin
         if (dcnt == 32) begin
            busy      <= 1'b0;
            div_ready <= 1'b1;
            if (div_signed)
               div_result <= {32'($signed(div_opdata1) % $signed(div_opdata2)),
                              32'($signed(div_opdata1) / $signed(div_opdata2))};
            else
               div_result <= {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
         end else begin
            dcnt <= dcnt + 1;
         end
      end else if (div_start && !div_ready) begin
         busy <= 1'b1;
         dcnt <= 1;
      end
   end

   initial div_result = 64'h0;

   // Event counters for launch checks
   always @(negedge clk) begin
      if (mul_start) begin
         mul_starts++;
         last_msigned = mul_signed;
      end
      if (div_start) div_start_cyc++;
   end

   // Monitor: pop on the first result cycle, then require the held value to stay put
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid && !rv_q) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got hi=0x%0h lo=0x%0h, expected no result", hi_o, lo_o);
            end else begin
               last_exp = exp_q.pop_front();
               check("result", {hi_o, lo_o}, last_exp);
            end
         end else if (res_valid) begin
            check("result_held", {hi_o, lo_o}, last_exp);
         end
      end
      rv_q = res_valid;
   end

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int hold,
                         input int exp_lat);
      int lat;
      int rv;
      exp_q.push_back(exp);
      @(negedge clk);
      req_op     = op;
      req_src1   = a;
      req_src2   = b;
      stall_hold = (hold > 0);
      #1;
      check({name, "_stallreq_req"}, 64'(stallreq), 64'd1);
      lat = 0;
      while (!res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         if (!res_valid) check({name, "_stallreq_busy"}, 64'(stallreq), 64'd1);
      end
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      rv = 0;
      while (res_valid && rv < 20) begin
         rv++;
         check({name, "_stallreq_done"}, 64'(stallreq), 64'd0);
         if (rv == hold + 1) begin
            stall_hold = 1'b0;
            req_op     = 4'h0;
         end
         @(negedge clk);
      end
      req_op     = 4'h0;
      stall_hold = 1'b0;
      check({name, "_valid_cycles"}, 64'(rv), 64'(hold + 1));
   endtask

   initial begin
      int ms0;
      int ds0;
      rst = 1'b1; flush = 1'b0; stall_hold = 1'b0;
      req_op = 4'h0; req_src1 = 32'h0; req_src2 = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_stallreq", 64'(stallreq), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_hilo", {hi_o, lo_o}, 64'h0);
      check("rst_starts", {62'h0, mul_start, div_start}, 64'h0);
      check("rst_div_ops", {div_opdata1, div_opdata2}, 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // multu 0xFFFFFFFF * 2
      ms0 = mul_starts;
      run_op("multu", 4'b0001, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 0, 3);
      check("multu_starts", 64'(mul_starts - ms0), 64'd1);
      check("multu_unsigned", 64'(last_msigned), 64'd0);

      // mult -3 * 5
      run_op("mult", 4'b0010, 32'hFFFF_FFFD, 32'h5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 3);
      check("mult_signed", 64'(last_msigned), 64'd1);

      // div -7 / 2: remainder -1, quotient -3
      ds0 = div_start_cyc;
      run_op("div", 4'b1000, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 35);
      check("div_start_cycles", 64'(div_start_cyc - ds0), 64'd34);

      // divu 5 / 0: no divider launch, one stall cycle
      ds0 = div_start_cyc;
      run_op("divu0", 4'b0100, 32'h5, 32'h0, 64'h0000_0005_FFFF_FFFF, 0, 1);
      check("divu0_no_start", 64'(div_start_cyc - ds0), 64'd0);

      // divu 100 / 7 flushed on DIV_RUN cycle 10
      @(negedge clk);
      req_op = 4'b0100; req_src1 = 32'd100; req_src2 = 32'd7;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_annul", 64'(div_annul), 64'd1);
      check("flush_div_start", 64'(div_start), 64'd0);
      req_op = 4'h0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_idle_stallreq", 64'(stallreq), 64'd0);
      check("flush_annul_off", 64'(div_annul), 64'd0);
      check("flush_hilo", {hi_o, lo_o}, 64'h0);
      repeat (40) @(negedge clk);
      run_op("divu_clean", 4'b0100, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 35);

      // mult 7 * -2 held four cycles in DONE
      ms0 = mul_starts;
      run_op("mult_hold", 4'b0010, 32'h7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 4, 3);
      check("hold_one_start", 64'(mul_starts - ms0), 64'd1);

      // Multiple op bits: div wins over everything, mult over multu
      run_op("prio_div", 4'b1111, 32'd20, 32'd6, 64'h0000_0002_0000_0003, 0, 35);
      run_op("prio_mult", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 3);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
